capture_ctrl: RTL and testbench

CAPTURE_CTRL -- requirements
Module: capture_ctrl

---
 rtl/capture_ctrl.sv | 149 ++++++++++++++
 tb/tb_capture_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// Capture sequencer for the sample buffer: pre-trigger fill, circular arming,
// post-trigger fill and a done handshake, with sample-rate decimation.
module capture_ctrl #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              smpl_tick,
  input  logic [1:0]        trig_type,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [3:0]        decimator,
  input  logic              triggered,
  input  logic              clr_cap_done,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              armed,
  output logic              capture_done
);

  localparam int               CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [1:0]       TT_NORMAL = 2'b01;
  localparam logic [1:0]       TT_AUTO   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] r_trig_addr;
  logic [ADDR_W-1:0] r_trig_pos;
  logic [3:0]        r_decim;
  logic [14:0]       r_dec_cnt;
  logic [CNT_W-1:0]  r_smp_cnt;
  logic [CNT_W-1:0]  w_smp_cnt_next;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [CNT_W-1:0]  w_pre_target;
  logic [CNT_W-1:0]  w_post_target;
  logic [14:0]       w_dec_mask;
  logic              w_run;
  logic              w_capturing;
  logic              w_dec_tick;
  logic              w_trig;
  logic              w_we;
  logic              w_start;

  assign w_run         = (trig_type == TT_NORMAL) || (trig_type == TT_AUTO);
  assign w_capturing   = r_state inside {S_PRE, S_ARMED, S_POST};
  assign w_dec_mask    = 15'((16'd1 << r_decim) - 16'd1);
  assign w_dec_tick    = smpl_tick && (r_dec_cnt == '0);
  assign w_cnt_inc     = r_smp_cnt + CNT_W'(1);
  assign w_pre_target  = DEPTH - {1'b0, r_trig_pos};
  assign w_post_target = {1'b0, r_trig_pos};
  // Auto-roll triggers on the very first ARMED cycle; normal waits for the pulse.
  assign w_trig        = (r_state == S_ARMED) &&
                         ((trig_type == TT_AUTO) || ((trig_type == TT_NORMAL) && triggered));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_next         = r_state;
    w_we           = 1'b0;
    w_start        = 1'b0;
    w_smp_cnt_next = r_smp_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_run) begin
          w_next         = S_PRE;
          w_start        = 1'b1;
          w_smp_cnt_next = '0;
        end
      end
      S_PRE: begin
        if (!w_run) begin
          w_next = S_IDLE;
        end else if (w_dec_tick) begin
          w_we           = 1'b1;
          w_smp_cnt_next = w_cnt_inc;
          if (w_cnt_inc == w_pre_target) w_next = S_ARMED;
        end
      end
      S_ARMED: begin
        if (!w_run) begin
          w_next = S_IDLE;
        end else if (w_trig) begin
          // A coincident write is the first post-trigger sample, unless none are wanted.
          w_we           = w_dec_tick && (r_trig_pos != '0);
          w_smp_cnt_next = {{ADDR_W{1'b0}}, w_we};
          w_next         = (w_smp_cnt_next == w_post_target) ? S_DONE : S_POST;
        end else if (w_dec_tick) begin
          w_we = 1'b1;
        end
      end
      S_POST: begin
        if (!w_run) begin
          w_next = S_IDLE;
        end else if (w_dec_tick) begin
          w_we           = 1'b1;
          w_smp_cnt_next = w_cnt_inc;
          if (w_cnt_inc == w_post_target) w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (clr_cap_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_waddr     <= '0;
      r_trig_addr <= '0;
      r_trig_pos  <= '0;
      r_decim     <= '0;
      r_dec_cnt   <= '0;
      r_smp_cnt   <= '0;
    end else begin
      r_state   <= w_next;
      r_smp_cnt <= w_smp_cnt_next;
      if (w_start) begin
        r_waddr    <= '0;
        r_dec_cnt  <= '0;
        r_trig_pos <= trig_pos;
        r_decim    <= decimator;
      end else begin
        if (w_we) r_waddr <= r_waddr + ADDR_W'(1);
        if (w_capturing && smpl_tick)
          r_dec_cnt <= (r_dec_cnt == w_dec_mask) ? '0 : r_dec_cnt + 15'd1;
      end
      if (w_trig) r_trig_addr <= r_waddr;
    end
  end

  assign we           = w_we;
  assign waddr        = r_waddr;
  assign trig_addr    = r_trig_addr;
  assign armed        = (r_state == S_ARMED);
  assign capture_done = (r_state == S_DONE);

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: expected RAM writes go into a scoreboard
// queue and a negedge monitor pops one entry per observed write.
module tb_capture_ctrl;

  localparam int ADDR_W = 9;
  localparam int D      = 512;

  logic              clk          = 1'b0;
  logic              rst_n        = 1'b0;
  logic              smpl_tick    = 1'b0;
  logic [1:0]        trig_type    = 2'b00;
  logic [ADDR_W-1:0] trig_pos     = '0;
  logic [3:0]        decimator    = '0;
  logic              triggered    = 1'b0;
  logic              clr_cap_done = 1'b0;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] trig_addr;
  logic              armed;
  logic              capture_done;

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  int cyc      = 0;

  typedef struct {
    int                cyc;   // -1: any cycle
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t sb[$];

  capture_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .smpl_tick    (smpl_tick),
    .trig_type    (trig_type),
    .trig_pos     (trig_pos),
    .decimator    (decimator),
    .triggered    (triggered),
    .clr_cap_done (clr_cap_done),
    .we           (we),
    .waddr        (waddr),
    .trig_addr    (trig_addr),
    .armed        (armed),
    .capture_done (capture_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic void push_seq(input int first, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.cyc  = -1;
      e.addr = ADDR_W'((first + k) % D);
      sb.push_back(e);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_armed(input string name);
    for (int i = 0; i < 2000; i++) begin
      step();
      if (armed === 1'b1) break;
    end
    check(name, armed, 1);
  endtask

  task automatic wait_done(input string name, output int armed_cyc);
    armed_cyc = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (armed === 1'b1) armed_cyc++;
      if (capture_done === 1'b1) break;
    end
    check(name, capture_done, 1);
  endtask

  task automatic clear_done(input string name);
    trig_type    = 2'b00;
    clr_cap_done = 1'b1;
    step();
    clr_cap_done = 1'b0;
    check(name, capture_done, 0);
  endtask

  // Monitor: every write the DUT presents must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (we !== 1'b0) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_we: write at addr %0d in cycle %0d, none expected", waddr, cyc);
        end else begin
          e = sb.pop_front();
          n_writes++;
          check("wr_addr", waddr, e.addr);
          if (e.cyc >= 0) check("wr_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    int ac;
    int k;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", we, 0);
    check("rst_waddr", waddr, 0);
    check("rst_trig_addr", trig_addr, 0);
    check("rst_armed", armed, 0);
    check("rst_capture_done", capture_done, 0);
    rst_n = 1'b1;
    step();

    // Normal trigger, half pre / half post, trigger 20 clks into ARMED
    trig_type = 2'b01;
    trig_pos  = 9'h100;
    decimator = 4'd0;
    smpl_tick = 1'b1;
    push_seq(0, 532);
    base = n_writes;
    step();
    clr_cap_done = 1'b1;
    step();
    clr_cap_done = 1'b0;
    wait_armed("t1_armed");
    check("t1_pre_writes", n_writes - base, 256);
    repeat (20) step();
    triggered = 1'b1;
    step();
    triggered = 1'b0;
    wait_done("t1_done", ac);
    check("t1_trig_addr", trig_addr, 9'h114);
    check("t1_waddr_hold", waddr, 20);
    check("t1_armed_low", armed, 0);
    check("t1_total_writes", n_writes - base, 532);
    check("t1_drained", sb.size(), 0);
    clear_done("t1_clr");

    // Auto roll: one ARMED cycle, forced trigger
    trig_type = 2'b10;
    trig_pos  = 9'h134;
    push_seq(0, 512);
    base = n_writes;
    step();
    wait_done("t2_done", ac);
    check("t2_armed_cycles", ac, 1);
    check("t2_trig_addr", trig_addr, 9'h0CC);
    check("t2_waddr_hold", waddr, 0);
    check("t2_total_writes", n_writes - base, 512);
    check("t2_drained", sb.size(), 0);
    clear_done("t2_clr");

    // Decimation by 4 on a tick every 4 clks, params changed mid-capture, then abort
    trig_type = 2'b01;
    trig_pos  = 9'h1FC;
    decimator = 4'd2;
    smpl_tick = 1'b0;
    step();
    k = 0;
    for (int c = 0; c <= 100; c++) begin
      smpl_tick = (c % 4 == 0);
      triggered = (c == 20);
      if (c == 2)  trig_pos  = 9'h000;
      if (c == 3)  decimator = 4'd0;
      if (c == 96) trig_type = 2'b00;
      if ((c % 16 == 0) && (c < 96)) begin
        exp_t e;
        e.cyc  = cyc;
        e.addr = ADDR_W'(k);
        sb.push_back(e);
        k++;
      end
      if (c == 40) check("t3_pre_ignores_trig", armed, 0);
      if (c == 60) check("t3_armed", armed, 1);
      step();
    end
    smpl_tick = 1'b1;
    triggered = 1'b0;
    check("t3_abort_armed", armed, 0);
    check("t3_abort_no_done", capture_done, 0);
    check("t3_drained", sb.size(), 0);

    // trig_pos = 0: full pre fill, wrap in ARMED, done right after trigger
    trig_type = 2'b01;
    trig_pos  = 9'h000;
    decimator = 4'd0;
    push_seq(0, 514);
    base = n_writes;
    step();
    triggered = 1'b1;
    step();
    triggered = 1'b0;
    wait_armed("t4_armed");
    check("t4_pre_writes", n_writes - base, 512);
    repeat (2) step();
    triggered = 1'b1;
    step();
    triggered = 1'b0;
    check("t4_done_next_cycle", capture_done, 1);
    check("t4_trig_addr", trig_addr, 2);
    check("t4_waddr_hold", waddr, 2);
    check("t4_drained", sb.size(), 0);

    // Clear from DONE restarts; reset lands mid-POST
    trig_pos     = 9'h008;
    clr_cap_done = 1'b1;
    push_seq(0, 506);
    step();
    clr_cap_done = 1'b0;
    check("t5_done_cleared", capture_done, 0);
    wait_armed("t5_armed");
    triggered = 1'b1;
    step();
    triggered = 1'b0;
    check("t5_trig_addr", trig_addr, 504);
    @(negedge clk);
    #1;
    rst_n     = 1'b0;
    trig_type = 2'b00;
    #1;
    check("t5_rst_we", we, 0);
    check("t5_rst_waddr", waddr, 0);
    check("t5_rst_trig_addr", trig_addr, 0);
    check("t5_rst_armed", armed, 0);
    check("t5_rst_capture_done", capture_done, 0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) step();
    check("t5_idle_waddr", waddr, 0);
    check("t5_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
